uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one uart_tx between NUM_REQ byte producers (CPU MMIO path, debug, DMA...).
//  Round-robin grant; sequences each byte: accept -> issue tx_data_valid pulse -> wait tx_busy rise -> wait fall.
//  Sits between requesters and uart_tx; replaces direct tx_data/tx_data_valid drive.
// PARAMETERS
//  NUM_REQ        4   number of requesters (2..8)
//  START_TIMEOUT  8   max cycles to wait for tx_busy rise after pulse (1..255)
// PORTS
//  clk          in   1            single clock, rising edge
//  reset        in   1            synchronous, active-high
//  req_valid    in   NUM_REQ      requester i has a byte; held until accepted
//  req_data     in   NUM_REQ*8    requester i byte at [8i+7:8i]
//  req_ready    out  NUM_REQ      one-hot accept; transfer on edge with valid&ready
//  tx_data      out  8            byte to uart_tx
//  tx_data_valid out 1            one-cycle start pulse to uart_tx
//  tx_busy      in   1            uart_tx transmitting
//  grant_id     out  clog2(NUM_REQ) requester of byte in flight
//  arb_busy     out  1            state != IDLE
//  timeout_err  out  1            sticky: tx_busy never rose within START_TIMEOUT
//  req_last     in   NUM_REQ      only with UART_TX_ARB_LOCK_EN
// BEHAVIOUR
//  Reset: state IDLE, tx_data=0, tx_data_valid=0, req_ready=0, grant_id=0, arb_busy=0, timeout_err=0,
//   rr pointer -> requester 0 highest priority. Reset mid-operation: accepted byte dropped, never re-issued.
//  FSM IDLE -> ISSUE -> WAIT_START -> WAIT_DONE -> IDLE.
//  IDLE: if any req_valid and !tx_busy: pick first valid from ptr upward, wrap NUM_REQ-1 -> 0.
//   req_ready[i] combinational, high only in IDLE for winner; edge: tx_data<=req_data[i], grant_id<=i,
//   ptr<=i+1 mod NUM_REQ, -> ISSUE. tx_busy high in IDLE: no req_ready.
//  ISSUE: tx_data_valid=1 exactly this cycle (valid seen at edge t -> pulse in cycle t+1); counter clear; -> WAIT_START.
//  WAIT_START: tx_busy=1 -> WAIT_DONE; else count; count==START_TIMEOUT -> timeout_err<=1, -> IDLE.
//  WAIT_DONE: tx_busy=0 -> IDLE. Earliest next accept: cycle after IDLE entered.
//  tx_data held stable from accept until next accept. At most one byte in flight; no internal FIFO.
//  Counter 8 bits, saturating never reached (bounded by START_TIMEOUT).
//  timeout_err cleared only by reset.
// CONFIGURATION
//  UART_TX_ARB_LOCK_EN defined: req_last port present; byte from i with req_last[i]=0 locks grant to i;
//   IDLE then considers only i (others wait) until a byte from i with req_last=1 accepted; ptr updates then.
//   timeout or reset releases lock.
//  Undefined: no req_last port; every byte arbitrated independently.
// STRUCTURE
//  Package uart_pkg: state enum (IDLE/ISSUE/WAIT_START/WAIT_DONE), UART_DATA_W=8, clog2 helper.
//  Sub-module uart_rr_pick: combinational rotate-priority picker (valid vector, ptr -> one-hot, index, any).
// TESTING
//  req_valid[2]=1 data 0x41, tx_busy low -> req_ready[2] 1 cycle, tx_data=0x41, tx_data_valid next cycle, grant_id=2.
//  All 4 valid continuously, uart model busy 10 cycles -> accept order 0,1,2,3,0; one pulse per byte.
//  tx_busy held 1 in IDLE with req0 valid -> no req_ready until tx_busy falls.
//  tx_busy never rises -> IDLE 8 cycles after WAIT_START entry, timeout_err=1, next request served.
//  reset in WAIT_DONE with req3 pending -> all outputs reset next cycle; after release req3 accepted, ptr from 0.
//  LOCK_EN: req1 3 bytes (last on 3rd), req0 valid throughout -> order 1,1,1,0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the uart_tx arbiter slice.
package uart_pkg;

    localparam int unsigned UART_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ISSUE      = 2'd1,
        WAIT_START = 2'd2,
        WAIT_DONE  = 2'd3
    } state_t;

    // Index width for v entries; never below 1 so a 1-bit id still exists.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 1;
        while ((32'd1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester/uart_tx side signals of the arbiter; master = arbiter, slave = environment.
// req_last exists only when UART_TX_ARB_LOCK_EN is defined.
interface uart_tx_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    localparam int unsigned ID_W = uart_pkg::clog2(NUM_REQ);
    localparam int unsigned DW   = uart_pkg::UART_DATA_W;

    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*DW-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ready;
    logic [DW-1:0]         tx_data;
    logic                  tx_data_valid;
    logic                  tx_busy;
    logic [ID_W-1:0]       grant_id;
    logic                  arb_busy;
    logic                  timeout_err;
`ifdef UART_TX_ARB_LOCK_EN
    logic [NUM_REQ-1:0]    req_last;

    modport master (
        input  req_valid, req_data, req_last, tx_busy,
        output req_ready, tx_data, tx_data_valid, grant_id, arb_busy, timeout_err
    );
    modport slave (
        output req_valid, req_data, req_last, tx_busy,
        input  req_ready, tx_data, tx_data_valid, grant_id, arb_busy, timeout_err
    );
`else
    modport master (
        input  req_valid, req_data, tx_busy,
        output req_ready, tx_data, tx_data_valid, grant_id, arb_busy, timeout_err
    );
    modport slave (
        output req_valid, req_data, tx_busy,
        input  req_ready, tx_data, tx_data_valid, grant_id, arb_busy, timeout_err
    );
`endif
endinterface

// File: rtl/uart_rr_pick.sv
// Rotating-priority picker: first set bit of valid at or above ptr, wrapping to 0.
module uart_rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx,
    output logic               any
);
    int unsigned cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = 0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            cand = (32'(ptr) + off) % NUM_REQ;
            if (!any && valid[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = ID_W'(cand);
            end
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NUM_REQ byte producers.
// Optional UART_TX_ARB_LOCK_EN: req_last keeps the grant on one requester for a burst.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned START_TIMEOUT = 8
) (
    input  logic clk,
    input  logic reset,
    uart_tx_arbiter_if.master bus
);
    localparam int unsigned ID_W = clog2(NUM_REQ);

    state_t                 state;
    logic [ID_W-1:0]        ptr;
    logic [ID_W-1:0]        ptr_next;
    logic [ID_W-1:0]        grant_q;
    logic [UART_DATA_W-1:0] tx_data_q;
    logic [7:0]             cnt;
    logic                   timeout_q;
    logic [NUM_REQ-1:0]     cand_valid;
    logic [NUM_REQ-1:0]     pick_grant;
    logic [ID_W-1:0]        pick_idx;
    logic                   pick_any;
    logic                   accept;

`ifdef UART_TX_ARB_LOCK_EN
    logic lock_active;

    // While locked only the current owner (grant_q) is eligible.
    always_comb begin
        cand_valid = bus.req_valid;
        if (lock_active) begin
            cand_valid          = '0;
            cand_valid[grant_q] = bus.req_valid[grant_q];
        end
    end
`else
    assign cand_valid = bus.req_valid;
`endif

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .valid (cand_valid),
        .ptr   (ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign accept   = !reset && (state == IDLE) && !bus.tx_busy && pick_any;
    assign ptr_next = (32'(pick_idx) == NUM_REQ - 1) ? '0 : ID_W'(pick_idx + 1'b1);

    assign bus.req_ready     = accept ? pick_grant : '0;
    assign bus.tx_data       = tx_data_q;
    assign bus.tx_data_valid = (state == ISSUE);
    assign bus.grant_id      = grant_q;
    assign bus.arb_busy      = (state != IDLE);
    assign bus.timeout_err   = timeout_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            grant_q   <= '0;
            tx_data_q <= '0;
            cnt       <= '0;
            timeout_q <= 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
            lock_active <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        tx_data_q <= bus.req_data[32'(pick_idx)*UART_DATA_W +: UART_DATA_W];
                        grant_q   <= pick_idx;
                        state     <= ISSUE;
`ifdef UART_TX_ARB_LOCK_EN
                        if (bus.req_last[pick_idx]) begin
                            ptr         <= ptr_next;
                            lock_active <= 1'b0;
                        end else begin
                            lock_active <= 1'b1;
                        end
`else
                        ptr <= ptr_next;
`endif
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT_START;
                end
                WAIT_START: begin
                    // cnt counts completed WAIT_START cycles; give up after START_TIMEOUT of them.
                    if (bus.tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (cnt == 8'(START_TIMEOUT - 1)) begin
                        timeout_q <= 1'b1;
                        state     <= IDLE;
`ifdef UART_TX_ARB_LOCK_EN
                        lock_active <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                WAIT_DONE: begin
                    if (!bus.tx_busy) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter with a small uart_tx busy model.
module tb_uart_tx_arbiter;

    logic clk = 1'b0;
    logic reset;
    logic force_busy;
    logic uart_en;
    int   busy_len;
    int   uart_left;

    int n_checks = 0;
    int n_fail   = 0;

    int         acc_q[$];
    logic [7:0] pd_q[$];
    int         n_pulse;

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(4)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ       (4),
        .START_TIMEOUT (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // uart_tx stand-in: busy for busy_len cycles starting the cycle after the start pulse.
    always @(posedge clk) begin
        if (reset) uart_left <= 0;
        else if (uart_en && bus.tx_data_valid) uart_left <= busy_len;
        else if (uart_left != 0) uart_left <= uart_left - 1;
    end
    assign bus.tx_busy = force_busy | (uart_left != 0);

    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++)
                if (bus.req_valid[i] && bus.req_ready[i]) acc_q.push_back(i);
            if (bus.tx_data_valid) begin
                n_pulse++;
                pd_q.push_back(bus.tx_data);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        for (int c = 0; c < 100 && bus.arb_busy; c++) @(negedge clk);
        #1;
        check(tag, bus.arb_busy, 0);
    endtask

    int exp_order[5] = '{0, 1, 2, 3, 0};

    initial begin
        reset         = 1'b1;
        force_busy    = 1'b0;
        uart_en       = 1'b1;
        busy_len      = 3;
        n_pulse       = 0;
        bus.req_valid = '0;
        bus.req_data  = '0;
`ifdef UART_TX_ARB_LOCK_EN
        bus.req_last  = '1;
`endif
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_tx_data", bus.tx_data, 0);
        check("rst_tx_valid", bus.tx_data_valid, 0);
        check("rst_grant", bus.grant_id, 0);
        check("rst_arb_busy", bus.arb_busy, 0);
        check("rst_timeout", bus.timeout_err, 0);

        // single byte from requester 2
        @(negedge clk);
        bus.req_data[23:16] = 8'h41;
        bus.req_valid       = 4'b0100;
        #1;
        check("t1_ready", bus.req_ready, 4'b0100);
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        check("t1_tx_data", bus.tx_data, 8'h41);
        check("t1_pulse", bus.tx_data_valid, 1);
        check("t1_grant", bus.grant_id, 2);
        check("t1_ready_off", bus.req_ready, 0);
        check("t1_arb_busy", bus.arb_busy, 1);
        @(negedge clk);
        #1;
        check("t1_pulse_end", bus.tx_data_valid, 0);
        wait_idle("t1_idle");
        check("t1_data_held", bus.tx_data, 8'h41);

        // all four valid, fresh pointer: round-robin 0,1,2,3,0
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        acc_q.delete();
        pd_q.delete();
        n_pulse  = 0;
        busy_len = 10;
        for (int i = 0; i < 4; i++) bus.req_data[i*8 +: 8] = 8'(8'h10 + i);
        bus.req_valid = 4'hF;
        for (int c = 0; c < 400 && acc_q.size() < 5; c++) @(negedge clk);
        bus.req_valid = '0;
        check("t2_accepts", acc_q.size(), 5);
        wait_idle("t2_idle");
        check("t2_pulses", n_pulse, 5);
        for (int k = 0; k < 5; k++) begin
            if (k < acc_q.size()) check("t2_order", acc_q[k], exp_order[k]);
            if (k < pd_q.size()) check("t2_data", pd_q[k], 8'h10 + exp_order[k]);
        end

        // tx_busy high while idle blocks acceptance
        @(negedge clk);
        force_busy        = 1'b1;
        bus.req_data[7:0] = 8'hC3;
        bus.req_valid     = 4'b0001;
        for (int c = 0; c < 4; c++) begin
            #1;
            check("t3_blocked", bus.req_ready, 0);
            @(negedge clk);
        end
        force_busy = 1'b0;
        #1;
        check("t3_ready", bus.req_ready, 4'b0001);
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        check("t3_grant", bus.grant_id, 0);
        check("t3_tx_data", bus.tx_data, 8'hC3);
        wait_idle("t3_idle");

        // tx_busy never rises: back to IDLE 8 cycles after WAIT_START entry
        @(negedge clk);
        uart_en            = 1'b0;
        bus.req_data[15:8] = 8'h5A;
        bus.req_valid      = 4'b0010;
        #1;
        check("t4_ready", bus.req_ready, 4'b0010);
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        check("t4_pulse", bus.tx_data_valid, 1);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            #1;
            check("t4_waiting", bus.arb_busy, 1);
        end
        check("t4_no_err_yet", bus.timeout_err, 0);
        @(negedge clk);
        #1;
        check("t4_idle", bus.arb_busy, 0);
        check("t4_timeout", bus.timeout_err, 1);
        @(negedge clk);
        uart_en             = 1'b1;
        busy_len            = 3;
        bus.req_data[23:16] = 8'h77;
        bus.req_valid       = 4'b0100;
        #1;
        check("t4_next_ready", bus.req_ready, 4'b0100);
        @(negedge clk);
        bus.req_valid = '0;
        wait_idle("t4_next_idle");
        check("t4_sticky", bus.timeout_err, 1);

        // reset in WAIT_DONE with requester 3 pending
        @(negedge clk);
        busy_len            = 10;
        bus.req_data[23:16] = 8'h66;
        bus.req_valid       = 4'b0100;
        #1;
        check("t5_ready2", bus.req_ready, 4'b0100);
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        bus.req_data[31:24] = 8'h99;
        bus.req_valid       = 4'b1000;
        #1;
        check("t5_in_flight", bus.arb_busy, 1);
        check("t5_no_ready", bus.req_ready, 0);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("t5_rst_busy", bus.arb_busy, 0);
        check("t5_rst_data", bus.tx_data, 0);
        check("t5_rst_grant", bus.grant_id, 0);
        check("t5_rst_timeout", bus.timeout_err, 0);
        check("t5_rst_ready", bus.req_ready, 0);
        check("t5_rst_pulse", bus.tx_data_valid, 0);
        reset   = 1'b0;
        n_pulse = 0;
        #1;
        check("t5_ready3", bus.req_ready, 4'b1000);
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        check("t5_grant3", bus.grant_id, 3);
        check("t5_data3", bus.tx_data, 8'h99);
        wait_idle("t5_idle");
        check("t5_one_pulse", n_pulse, 1);

`ifdef UART_TX_ARB_LOCK_EN
        // burst of three from requester 1 with requester 0 waiting: 1,1,1,0
        @(negedge clk);
        busy_len          = 3;
        bus.req_data[7:0] = 8'hB0;
        bus.req_valid     = 4'b0001;
        @(negedge clk);
        bus.req_valid = '0;
        wait_idle("t6_pre_idle");
        @(negedge clk);
        acc_q.delete();
        bus.req_last[1]    = 1'b0;
        bus.req_data[15:8] = 8'hA0;
        bus.req_valid      = 4'b0011;
        for (int c = 0; c < 400 && acc_q.size() < 4; c++) begin
            @(negedge clk);
            begin
                int n1;
                n1 = 0;
                foreach (acc_q[j]) if (acc_q[j] == 1) n1++;
                bus.req_data[15:8] = 8'(8'hA0 + n1);
                bus.req_last[1]    = (n1 >= 2);
                if (n1 >= 3) bus.req_valid[1] = 1'b0;
            end
        end
        bus.req_valid = '0;
        bus.req_last  = '1;
        wait_idle("t6_idle");
        check("t6_accepts", acc_q.size(), 4);
        for (int k = 0; k < 4; k++)
            if (k < acc_q.size()) check("t6_order", acc_q[k], (k < 3) ? 1 : 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got running expected finished");
        $fatal(1, "watchdog expired");
    end

endmodule
